// File: rtl/fb_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : fb_scan_reader
// Brief    : Frame-buffer scanout read path, intensity-to-RGB mapping and
//            vblank-synchronised double-buffer bank select.
//            Optional erase-behind-scan enabled by macro FB_ERASE_ON_READ_EN.
// Revision : 1.0  initial release
// ============================================================================
module fb_scan_reader #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int RD_LAT     = 2,
    parameter bit MONO_GREEN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  row,
    input  logic [9:0]  col,
    input  logic        en_r,
    input  logic        vblank,
    output logic [18:0] rd_addr,
    output logic        rd_en,
    input  logic [3:0]  rd_data,
    output logic        buf_sel,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic [18:0] clr_addr,
    output logic        clr_we,
    output logic [3:0]  red_out,
    output logic [3:0]  green_out,
    output logic [3:0]  blue_out
);

    localparam logic [8:0] C_V_LIM = 9'(V_ACTIVE);
    localparam logic [9:0] C_H_LIM = 10'(H_ACTIVE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_ACK  = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    logic [18:0]       addr_calc;
    logic              rd_en_d;
    logic              rd_en_q;
    logic [18:0]       rd_addr_q;
    logic [RD_LAT-1:0] vld_q;
    logic [11:0]       rgb_q;
    state_t            state_q, state_d;
    logic              buf_sel_q, buf_sel_d;

    generate
        if (H_ACTIVE == 640) begin : g_addr_shift
            // row*640 = row*512 + row*128
            assign addr_calc = ({10'd0, row} << 9) + ({10'd0, row} << 7) + {9'd0, col};
        end else begin : g_addr_mul
            assign addr_calc = 19'(row) * 19'(H_ACTIVE) + 19'(col);
        end
    endgenerate

    assign rd_en_d = en_r && (row < C_V_LIM) && (col < C_H_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            vld_q     <= '0;
            rgb_q     <= '0;
        end else begin
            rd_en_q   <= rd_en_d;
            rd_addr_q <= addr_calc;
            vld_q[0]  <= rd_en_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            if (vld_q[RD_LAT-1]) begin
                rgb_q <= MONO_GREEN ? {4'h0, rd_data, 4'h0} : {rd_data, rd_data, rd_data};
            end else begin
                rgb_q <= '0;
            end
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign red_out   = rgb_q[11:8];
    assign green_out = rgb_q[7:4];
    assign blue_out  = rgb_q[3:0];

`ifdef FB_ERASE_ON_READ_EN
    logic [18:0] addr_pipe_q [RD_LAT];

    // Address travels alongside the valid bit so the erase hits exactly the pixel just read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                addr_pipe_q[i] <= '0;
            end
        end else begin
            addr_pipe_q[0] <= rd_addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                addr_pipe_q[i] <= addr_pipe_q[i-1];
            end
        end
    end

    assign clr_we   = vld_q[RD_LAT-1] & ~rst;
    assign clr_addr = addr_pipe_q[RD_LAT-1];
`else
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            buf_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_sel_q <= buf_sel_d;
        end
    end

    // A request must sit in PEND for at least one cycle before a vblank can grant it.
    always_comb begin
        state_d   = state_q;
        buf_sel_d = buf_sel_q;
        case (state_q)
            S_IDLE: if (swap_req) state_d = S_PEND;
            S_PEND: begin
                if (!swap_req) begin
                    state_d = S_IDLE;
                end else if (vblank) begin
                    state_d   = S_ACK;
                    buf_sel_d = ~buf_sel_q;
                end
            end
            S_ACK:  state_d = S_WAIT;
            S_WAIT: if (!swap_req) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign buf_sel  = buf_sel_q;
    assign swap_ack = (state_q == S_ACK);

endmodule
`default_nettype wire

// File: tb/tb_fb_scan_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fb_scan_reader
// Brief    : Scoreboard bench for fb_scan_reader (raster reads, RGB, swap FSM).
// Revision : 1.0  initial release
// ============================================================================
module tb_fb_scan_reader;

    localparam int C_RD_LAT = 2;
    localparam int C_H      = 640;
    localparam int C_V      = 480;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  row = '0;
    logic [9:0]  col = '0;
    logic        en_r = 1'b0;
    logic        vblank = 1'b0;
    logic [18:0] rd_addr;
    logic        rd_en;
    logic [3:0]  rd_data;
    logic        buf_sel;
    logic        swap_req = 1'b0;
    logic        swap_ack;
    logic [18:0] clr_addr;
    logic        clr_we;
    logic [3:0]  red_out, green_out, blue_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int          due;
        logic        en;
        logic [18:0] addr;
        logic [11:0] rgb;
    } exp_t;

    exp_t qa[$];
    exp_t qc[$];
    exp_t qr[$];

    logic [3:0] ram_q [C_RD_LAT] = '{default: 4'h0};

    fb_scan_reader #(
        .H_ACTIVE   (C_H),
        .V_ACTIVE   (C_V),
        .RD_LAT     (C_RD_LAT),
        .MONO_GREEN (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .en_r      (en_r),
        .vblank    (vblank),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .buf_sel   (buf_sel),
        .swap_req  (swap_req),
        .swap_ack  (swap_ack),
        .clr_addr  (clr_addr),
        .clr_we    (clr_we),
        .red_out   (red_out),
        .green_out (green_out),
        .blue_out  (blue_out)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] pix(input logic [18:0] a);
        return a[3:0] ^ a[7:4];
    endfunction

    // Framebuffer stand-in: contents are a fixed function of the address.
    always @(posedge clk) begin
        ram_q[0] <= pix(rd_addr);
        for (int i = 1; i < C_RD_LAT; i++) ram_q[i] <= ram_q[i-1];
    end
    assign rd_data = ram_q[C_RD_LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at cyc %0d", tag, obs, exp, cyc);
            $error("check %s", tag);
        end
    endtask

    // Expectations are derived from the inputs seen at each edge.
    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (rst) begin
            qa.delete();
            qc.delete();
            qr.delete();
            e.en = 1'b0; e.addr = '0; e.rgb = '0;
            e.due = cyc; qa.push_back(e);
            for (int k = 0; k < C_RD_LAT; k++) begin e.due = cyc + k; qc.push_back(e); end
            for (int k = 0; k <= C_RD_LAT; k++) begin e.due = cyc + k; qr.push_back(e); end
        end else begin
            e.en   = en_r && (int'(row) < C_V) && (int'(col) < C_H);
            e.addr = 19'(int'(row) * C_H + int'(col));
            e.rgb  = e.en ? {4'h0, pix(e.addr), 4'h0} : 12'h0;
            e.due = cyc;                qa.push_back(e);
            e.due = cyc + C_RD_LAT;     qc.push_back(e);
            e.due = cyc + C_RD_LAT + 1; qr.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        while (qa.size() > 0 && qa[0].due < cyc) void'(qa.pop_front());
        while (qc.size() > 0 && qc[0].due < cyc) void'(qc.pop_front());
        while (qr.size() > 0 && qr[0].due < cyc) void'(qr.pop_front());
        if (qa.size() > 0 && qa[0].due == cyc) begin
            e = qa.pop_front();
            if (mon_en) begin
                chk("sb_rd_en", 32'(rd_en), 32'(e.en));
                if (e.en) chk("sb_rd_addr", 32'(rd_addr), 32'(e.addr));
            end
        end
        if (qc.size() > 0 && qc[0].due == cyc) begin
            e = qc.pop_front();
            if (mon_en) begin
`ifdef FB_ERASE_ON_READ_EN
                chk("sb_clr_we", 32'(clr_we), 32'(e.en && !rst));
                if (e.en && !rst) chk("sb_clr_addr", 32'(clr_addr), 32'(e.addr));
`else
                chk("sb_clr_we", 32'(clr_we), 32'd0);
                chk("sb_clr_addr", 32'(clr_addr), 32'd0);
`endif
            end
        end
        if (qr.size() > 0 && qr[0].due == cyc) begin
            e = qr.pop_front();
            if (mon_en) chk("sb_rgb", 32'({red_out, green_out, blue_out}), 32'(e.rgb));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic e, input int r, input int c);
        en_r = e;
        row  = 9'(r);
        col  = 10'(c);
        tick();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_buf_sel", 32'(buf_sel), 32'd0);
        chk("rst_swap_ack", 32'(swap_ack), 32'd0);
        chk("rst_rgb", 32'({red_out, green_out, blue_out}), 32'd0);
        chk("rst_clr_we", 32'(clr_we), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        step(1'b1, 0, 0);
        chk("addr_0_0_en", 32'(rd_en), 32'd1);
        chk("addr_0_0", 32'(rd_addr), 32'd0);
        step(1'b1, 1, 5);
        chk("addr_1_5", 32'(rd_addr), 32'd645);
        step(1'b1, 479, 639);
        chk("addr_479_639", 32'(rd_addr), 32'd307199);
        step(1'b1, 0, 700);
        chk("col_oob_en", 32'(rd_en), 32'd0);
        step(1'b1, 480, 0);
        chk("row_oob_en", 32'(rd_en), 32'd0);
        step(1'b0, 1, 1);
        chk("en_low", 32'(rd_en), 32'd0);

        // Address 10 holds intensity 4'hA in the stand-in framebuffer.
        step(1'b1, 0, 10);
        en_r = 1'b0;
        repeat (C_RD_LAT + 1) tick();
        chk("mono_green", 32'(green_out), 32'hA);
        chk("mono_red", 32'(red_out), 32'h0);
        chk("mono_blue", 32'(blue_out), 32'h0);

        // Erase timing relative to a single read at 645.
        step(1'b1, 1, 5);
        en_r = 1'b0;
        repeat (C_RD_LAT - 1) tick();
        chk("clr_early", 32'(clr_we), 32'd0);
        tick();
`ifdef FB_ERASE_ON_READ_EN
        chk("clr_we_645", 32'(clr_we), 32'd1);
        chk("clr_addr_645", 32'(clr_addr), 32'd645);
`else
        chk("clr_we_off", 32'(clr_we), 32'd0);
`endif

        for (int n = 0; n < 32; n++) begin
            step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 511)), int'($urandom_range(0, 1023)));
        end
        step(1'b1, 2, 0);
        step(1'b1, 2, 1);
        step(1'b1, 2, 2);

        // Reset with reads in flight: nothing may reach the RGB outputs.
        step(1'b1, 3, 3);
        en_r = 1'b1; row = 9'd4; col = 10'd4; rst = 1'b1;
        tick();
        rst = 1'b0; en_r = 1'b0;
        for (int n = 0; n <= C_RD_LAT + 1; n++) begin
            chk("rst_flush_rgb", 32'({red_out, green_out, blue_out}), 32'd0);
            tick();
        end

        swap_req = 1'b1; tick();
        chk("pend_ack", 32'(swap_ack), 32'd0);
        vblank = 1'b1; tick(); vblank = 1'b0;
        chk("swap1_ack", 32'(swap_ack), 32'd1);
        chk("swap1_buf", 32'(buf_sel), 32'd1);
        tick();
        chk("swap1_ack_drop", 32'(swap_ack), 32'd0);
        vblank = 1'b1; tick(); vblank = 1'b0;
        chk("held_req_ack", 32'(swap_ack), 32'd0);
        tick();
        chk("held_req_buf", 32'(buf_sel), 32'd1);
        swap_req = 1'b0; tick();
        swap_req = 1'b1; tick();
        vblank = 1'b1; tick(); vblank = 1'b0;
        chk("swap2_ack", 32'(swap_ack), 32'd1);
        chk("swap2_buf", 32'(buf_sel), 32'd0);
        tick();
        chk("swap2_ack_drop", 32'(swap_ack), 32'd0);
        swap_req = 1'b0; tick();

        swap_req = 1'b1; vblank = 1'b1; tick(); vblank = 1'b0;
        chk("same_cyc_ack", 32'(swap_ack), 32'd0);
        tick();
        chk("same_cyc_ack2", 32'(swap_ack), 32'd0);
        chk("same_cyc_buf", 32'(buf_sel), 32'd0);
        swap_req = 1'b0; tick();
        vblank = 1'b1; tick(); vblank = 1'b0;
        chk("withdrawn_ack", 32'(swap_ack), 32'd0);
        chk("withdrawn_buf", 32'(buf_sel), 32'd0);

        swap_req = 1'b1; tick();
        vblank = 1'b1; tick(); vblank = 1'b0;
        chk("swap3_buf", 32'(buf_sel), 32'd1);
        swap_req = 1'b0; tick(); tick();
        swap_req = 1'b1; tick();
        vblank = 1'b1; rst = 1'b1; tick(); vblank = 1'b0; rst = 1'b0;
        chk("rst_swap_ack", 32'(swap_ack), 32'd0);
        chk("rst_swap_buf", 32'(buf_sel), 32'd0);
        tick();
        chk("rst_swap_ack2", 32'(swap_ack), 32'd0);
        swap_req = 1'b0;
        repeat (C_RD_LAT + 3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
